// File: rtl/stream_fifo_pkg.sv
// Shared stream-library helpers: constant clog2 used to size pointers and occupancy counters.
package stream_fifo_pkg;

  // Ceiling log2 of n; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one asynchronous read port, no reset.
module fifo_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Synchronous rdy/ack stream FIFO; owns pointers, occupancy, flags and handshakes around fifo_mem.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_LVL = 3,
  localparam int unsigned PTR_W    = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int unsigned LVL_W    = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rdy_in,
  output logic              ack_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              rdy_out,
  input  logic              ack_out,
  output logic [DATA_W-1:0] data_out,
  output logic [LVL_W-1:0]  level,
  output logic              almost_full,
  output logic              overflow_err
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, push, pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  // Handshakes depend only on registered level; outputs show the reset state while rstn is low.
  assign ack_in      = !rstn || !full;
  assign rdy_out     = rstn && !empty;
  assign almost_full = rstn && (level_q >= LVL_W'(AFULL_LVL));

  assign push = rdy_in && ack_in;
  assign pop  = rdy_out && ack_out;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
    if (push && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (push && rstn),
    .waddr(wr_ptr_q),
    .wdata(data_in),
    .raddr(rd_ptr_q),
    .rdata(data_out)
  );

  assign level        = level_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: vector table for fill/drain/latency/reset plus hand sequences.
module tb_stream_fifo;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rdy_in, ack_out;
  logic [31:0] data_in;
  logic        ack_in, rdy_out, almost_full, overflow_err;
  logic [31:0] data_out;
  logic [2:0]  level;

  logic        rdy_in3, ack_out3;
  logic [31:0] data_in3;
  logic        ack_in3, rdy_out3, almost_full3, overflow_err3;
  logic [31:0] data_out3;
  logic [1:0]  level3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_fifo #(.DATA_W(32), .DEPTH(4), .AFULL_LVL(3)) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .rdy_in      (rdy_in),
    .ack_in      (ack_in),
    .data_in     (data_in),
    .rdy_out     (rdy_out),
    .ack_out     (ack_out),
    .data_out    (data_out),
    .level       (level),
    .almost_full (almost_full),
    .overflow_err(overflow_err)
  );

  stream_fifo #(.DATA_W(32), .DEPTH(3), .AFULL_LVL(2)) u_dut3 (
    .clk         (clk),
    .rstn        (rstn),
    .rdy_in      (rdy_in3),
    .ack_in      (ack_in3),
    .data_in     (data_in3),
    .rdy_out     (rdy_out3),
    .ack_out     (ack_out3),
    .data_out    (data_out3),
    .level       (level3),
    .almost_full (almost_full3),
    .overflow_err(overflow_err3)
  );

  typedef struct {
    logic        rstn;
    logic        rdy_in;
    logic [31:0] data_in;
    logic        ack_out;
    logic        ack_in;
    logic        rdy_out;
    logic [31:0] data_out;
    logic [2:0]  level;
    logic        af;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic r, logic ri, logic [31:0] di, logic ao, logic ai, logic ro,
                              logic [31:0] dout, logic [2:0] lv, logic af);
    vec_t v;
    v.rstn = r; v.rdy_in = ri; v.data_in = di; v.ack_out = ao;
    v.ack_in = ai; v.rdy_out = ro; v.data_out = dout; v.level = lv; v.af = af;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; rdy_in = 1'b0; ack_out = 1'b0; data_in = '0;
    rdy_in3 = 1'b0; ack_out3 = 1'b0; data_in3 = '0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcvd;
    logic p, q;

    vecs[0]  = mk(0, 0, 32'h00, 0, 1, 0, 32'h00, 0, 0);
    // fill to full while downstream stalls
    vecs[1]  = mk(1, 1, 32'hA0, 0, 1, 0, 32'h00, 0, 0);
    vecs[2]  = mk(1, 1, 32'hA1, 0, 1, 1, 32'hA0, 1, 0);
    vecs[3]  = mk(1, 1, 32'hA2, 0, 1, 1, 32'hA0, 2, 0);
    vecs[4]  = mk(1, 1, 32'hA3, 0, 1, 1, 32'hA0, 3, 1);
    vecs[5]  = mk(1, 1, 32'hA4, 0, 0, 1, 32'hA0, 4, 1);
    // drain in order
    vecs[6]  = mk(1, 0, 32'h00, 1, 0, 1, 32'hA0, 4, 1);
    vecs[7]  = mk(1, 0, 32'h00, 1, 1, 1, 32'hA1, 3, 1);
    vecs[8]  = mk(1, 0, 32'h00, 1, 1, 1, 32'hA2, 2, 0);
    vecs[9]  = mk(1, 0, 32'h00, 1, 1, 1, 32'hA3, 1, 0);
    vecs[10] = mk(1, 0, 32'h00, 0, 1, 0, 32'h00, 0, 0);
    // single-word latency: no pop possible while empty even with ack_out high
    vecs[11] = mk(1, 1, 32'h55, 1, 1, 0, 32'h00, 0, 0);
    vecs[12] = mk(1, 0, 32'h00, 0, 1, 1, 32'h55, 1, 0);
    vecs[13] = mk(1, 0, 32'h00, 1, 1, 1, 32'h55, 1, 0);
    vecs[14] = mk(1, 0, 32'h00, 0, 1, 0, 32'h00, 0, 0);
    // reset with two words in flight
    vecs[15] = mk(1, 1, 32'h11, 0, 1, 0, 32'h00, 0, 0);
    vecs[16] = mk(1, 1, 32'h22, 0, 1, 1, 32'h11, 1, 0);
    vecs[17] = mk(0, 0, 32'h00, 0, 1, 0, 32'h00, 2, 0);
    vecs[18] = mk(1, 1, 32'h77, 0, 1, 0, 32'h00, 0, 0);
    vecs[19] = mk(1, 0, 32'h00, 0, 1, 1, 32'h77, 1, 0);
    vecs[20] = mk(1, 0, 32'h00, 1, 1, 1, 32'h77, 1, 0);
    vecs[21] = mk(1, 0, 32'h00, 0, 1, 0, 32'h00, 0, 0);

    do_reset();

    foreach (vecs[i]) begin
      rstn = vecs[i].rstn; rdy_in = vecs[i].rdy_in;
      data_in = vecs[i].data_in; ack_out = vecs[i].ack_out;
      #1;
      check($sformatf("v%0d ack_in", i), 32'(ack_in), 32'(vecs[i].ack_in));
      check($sformatf("v%0d rdy_out", i), 32'(rdy_out), 32'(vecs[i].rdy_out));
      check($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].level));
      check($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vecs[i].af));
      check($sformatf("v%0d overflow_err", i), 32'(overflow_err), 32'd0);
      if (vecs[i].rdy_out) begin
        check($sformatf("v%0d data_out", i), data_out, vecs[i].data_out);
      end
      @(posedge clk);
      #1;
    end

    // Streaming: one primed word, then 20 cycles of simultaneous push and pop.
    do_reset();
    rdy_in = 1'b1; data_in = 32'h100; ack_out = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      rdy_in = 1'b1; data_in = 32'(i); ack_out = 1'b1;
      #1;
      check($sformatf("stream%0d level", i), 32'(level), 32'd1);
      check($sformatf("stream%0d ack_in", i), 32'(ack_in), 32'd1);
      check($sformatf("stream%0d rdy_out", i), 32'(rdy_out), 32'd1);
      check($sformatf("stream%0d data_out", i), data_out, (i == 0) ? 32'h100 : 32'(i - 1));
      tick();
    end
    rdy_in = 1'b0; ack_out = 1'b1;
    #1;
    check("stream tail data_out", data_out, 32'd19);
    tick();
    ack_out = 1'b0;
    #1;
    check("stream end level", 32'(level), 32'd0);

    // Full FIFO, rdy_in held high, single-cycle ack_out pulse.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rdy_in = 1'b1; data_in = 32'hB0 + 32'(i); ack_out = 1'b0;
      tick();
    end
    data_in = 32'hB4;
    #1;
    check("full ack_in", 32'(ack_in), 32'd0);
    ack_out = 1'b1;
    #1;
    check("pulse data_out", data_out, 32'hB0);
    check("pulse ack_in same cycle", 32'(ack_in), 32'd0);
    tick();
    ack_out = 1'b0;
    #1;
    check("after pulse level", 32'(level), 32'd3);
    check("after pulse ack_in", 32'(ack_in), 32'd1);
    tick();
    #1;
    check("refill level", 32'(level), 32'd4);
    check("refill ack_in", 32'(ack_in), 32'd0);
    rdy_in = 1'b0; ack_out = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      check($sformatf("pulse drain%0d", i), data_out, 32'hB0 + 32'(i));
      tick();
    end
    ack_out = 1'b0;
    #1;
    check("pulse drain empty", 32'(rdy_out), 32'd0);
    check("pulse overflow_err", 32'(overflow_err), 32'd0);

    // DEPTH=3 wrap with random stalls on both faces, scored against a level model.
    do_reset();
    sent = 0; rcvd = 0;
    for (int c = 0; c < 400 && rcvd < 10; c++) begin
      rdy_in3  = (sent < 10) && ($urandom_range(0, 1) == 1);
      data_in3 = 32'hC0 + 32'(sent);
      ack_out3 = ($urandom_range(0, 2) != 0);
      #1;
      check($sformatf("wrap c%0d level", c), 32'(level3), 32'(sent - rcvd));
      p = rdy_in3 && ack_in3;
      q = rdy_out3 && ack_out3;
      if (q) begin
        check($sformatf("wrap word%0d", rcvd), data_out3, 32'hC0 + 32'(rcvd));
        rcvd++;
      end
      if (p) sent++;
      tick();
    end
    rdy_in3 = 1'b0; ack_out3 = 1'b0;
    check("wrap words received", 32'(rcvd), 32'd10);
    check("wrap overflow_err", 32'(overflow_err3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
